// File: rtl/alignment_collector.sv
// alignment_collector: captures the aligned symbol pairs that traceback emits
// end-to-start, replays them start-to-end over a valid/ready stream, and
// rescores the alignment so it can be compared with traceback's final_score.
//
// Output handshake: a pair transfers on any rising edge where out_valid and
// out_ready are both high. out_valid never drops and out_a/out_b/out_idx/
// out_last never change while a pair is offered but not yet taken.
module alignment_collector #(
  parameter int         N        = 128,
  parameter int         BitAddr  = $clog2(N + 1),
  parameter int         DEPTH    = 2 * N,
  parameter int         PW       = $clog2(DEPTH + 1),
  parameter logic [2:0] GAP_CODE = 3'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pair_valid,
  input  logic [2:0]               datoA,
  input  logic [2:0]               datoB,
  input  logic                     end_c,
  input  logic signed [BitAddr:0]  final_score,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_a,
  output logic [2:0]               out_b,
  output logic [PW-1:0]            out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [PW-1:0]            n_match,
  output logic [PW-1:0]            n_mismatch,
  output logic [PW-1:0]            n_gap,
  output logic signed [BitAddr+2:0] score_calc,
  output logic                     score_ok,
  output logic [1:0]               fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = BitAddr + 3;
  localparam logic signed [SW-1:0] GAP_SCORE      = SW'(-2);
  localparam logic signed [SW-1:0] MATCH_SCORE    = SW'(1);
  localparam logic signed [SW-1:0] MISMATCH_SCORE = SW'(-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [5:0]              mem [DEPTH];
  logic [5:0]              rd_data;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           idx;
  logic [PW-1:0]           count_next;
  logic signed [BitAddr:0] score_latched;
  logic                    collecting;
  logic                    push;
  logic                    drop;
  logic                    xfer;
  logic                    is_gap;
  logic                    is_match;
  logic signed [SW-1:0]    delta;

  // Event decode; start masks every other event in the same cycle.
  always_comb begin
    collecting = (state == COLLECT) && !start;
    push       = collecting && pair_valid && (wr_ptr != PW'(DEPTH));
    drop       = collecting && pair_valid && (wr_ptr == PW'(DEPTH));
    xfer       = (state == DRAIN) && !start && out_ready;
    count_next = wr_ptr + PW'(push);
    is_gap     = (datoA == GAP_CODE) || (datoB == GAP_CODE);
    is_match   = !is_gap && (datoA == datoB);
    if (is_gap) begin
      delta = GAP_SCORE;
    end else if (is_match) begin
      delta = MATCH_SCORE;
    end else begin
      delta = MISMATCH_SCORE;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (end_c) state_next = (count_next != '0) ? DRAIN : DONE;
        DRAIN:   if (xfer && (rd_ptr == '0)) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  // Pointers, column statistics, running score and latched final_score.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      idx           <= '0;
      n_match       <= '0;
      n_mismatch    <= '0;
      n_gap         <= '0;
      score_calc    <= '0;
      score_latched <= '0;
      overflow      <= 1'b0;
    end else if (start) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      idx           <= '0;
      n_match       <= '0;
      n_mismatch    <= '0;
      n_gap         <= '0;
      score_calc    <= '0;
      score_latched <= '0;
      overflow      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= count_next;
        score_calc <= score_calc + delta;
        if (is_gap) begin
          n_gap <= n_gap + PW'(1);
        end else if (is_match) begin
          n_match <= n_match + PW'(1);
        end else begin
          n_mismatch <= n_mismatch + PW'(1);
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      // Drain starts from the newest entry, which is the first alignment column.
      if (collecting && end_c) begin
        score_latched <= final_score;
        rd_ptr        <= count_next - PW'(1);
      end
      if (xfer) begin
        rd_ptr <= rd_ptr - PW'(1);
        idx    <= idx + PW'(1);
      end
    end
  end

  // LIFO storage; contents are only observable while draining, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {datoA, datoB};
    end
  end

  // Outputs decoded from state; stream fields are zero whenever nothing is offered.
  always_comb begin
    out_valid = (state == DRAIN);
    busy      = (state == COLLECT) || (state == DRAIN);
    done      = (state == DONE);
    out_last  = out_valid && (rd_ptr == '0);
    out_a     = out_valid ? rd_data[5:3] : 3'd0;
    out_b     = out_valid ? rd_data[2:0] : 3'd0;
    out_idx   = out_valid ? idx : '0;
    score_ok  = done && (score_calc == {{2{score_latched[BitAddr]}}, score_latched});
    fsm_state = state;
  end

endmodule
